// File: rtl/ahb_bridge_arbiter.sv
// Round-robin arbiter and address/data mux sharing one AHB-to-APB bridge slave port
// between NUM_MASTERS masters; handover only at transfer boundaries, bursts hold the bus.
module ahb_bridge_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int MW          = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                      Hclk,
    input  logic                      Hresetn,
    input  logic [NUM_MASTERS-1:0]    Hbusreq,
    input  logic [NUM_MASTERS*32-1:0] m_Haddr,
    input  logic [NUM_MASTERS*2-1:0]  m_Htrans,
    input  logic [NUM_MASTERS-1:0]    m_Hwrite,
    input  logic [NUM_MASTERS*3-1:0]  m_Hsize,
    input  logic [NUM_MASTERS*3-1:0]  m_Hburst,
    input  logic [NUM_MASTERS*32-1:0] m_Hwdata,
    input  logic                      Hreadyout,
    output logic [NUM_MASTERS-1:0]    Hgrant,
    output logic [MW-1:0]             Hmaster,
    output logic [MW-1:0]             Hmaster_data,
    output logic                      Hready,
    output logic [31:0]               Haddr,
    output logic [1:0]                Htrans,
    output logic                      Hwrite,
    output logic [2:0]                Hsize,
    output logic [2:0]                Hburst,
    output logic [31:0]               Hwdata,
    output logic                      Hreadyin
);
    typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT, ARB_BURST} state_t;

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_BUSY   = 2'b01;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    state_t                 state, state_n;
    logic [3:0]             cnt, cnt_n;
    logic [MW-1:0]          ptr, ptr_n, master_n;
    logic [NUM_MASTERS-1:0] grant_n;
    logic                   arb_found, rearb;
    logic [MW-1:0]          arb_idx;

    assign Hready   = Hreadyout;
    assign Hreadyin = Hreadyout;

    // Search starts one past the last owner, so the current owner is considered last.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            if (!arb_found && Hbusreq[(int'(ptr) + i) % NUM_MASTERS]) begin
                arb_found = 1'b1;
                arb_idx   = MW'((int'(ptr) + i) % NUM_MASTERS);
            end
        end
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state        <= ARB_IDLE;
            cnt          <= '0;
            ptr          <= '0;
            Hgrant       <= '0;
            Hmaster      <= '0;
            Hmaster_data <= '0;
        end else if (Hreadyout) begin
            state        <= state_n;
            cnt          <= cnt_n;
            ptr          <= ptr_n;
            Hgrant       <= grant_n;
            Hmaster      <= master_n;
            Hmaster_data <= Hmaster;
        end
    end

    // cnt==0 while in ARB_BURST marks an unbounded INCR burst.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        ptr_n    = ptr;
        grant_n  = Hgrant;
        master_n = Hmaster;
        rearb    = 1'b0;
        case (state)
            ARB_GRANT: begin
                if (Htrans == TR_NONSEQ && Hburst != 3'b000) begin
                    state_n = ARB_BURST;
                    case (Hburst[2:1])
                        2'b00:   cnt_n = 4'd0;
                        2'b01:   cnt_n = 4'd3;
                        2'b10:   cnt_n = 4'd7;
                        default: cnt_n = 4'd15;
                    endcase
                end else begin
                    rearb = 1'b1;
                end
            end
            ARB_BURST: begin
                if (cnt == 4'd0) begin
                    rearb = !(Hbusreq[Hmaster] && (Htrans == TR_SEQ || Htrans == TR_BUSY));
                end else if (Htrans == TR_SEQ) begin
                    if (cnt == 4'd1) rearb = 1'b1;
                    else             cnt_n = cnt - 4'd1;
                end else begin
                    rearb = (Htrans != TR_BUSY);
                end
            end
            default: rearb = 1'b1;
        endcase
        if (rearb) begin
            cnt_n = '0;
            if (arb_found) begin
                state_n          = ARB_GRANT;
                grant_n          = '0;
                grant_n[arb_idx] = 1'b1;
                master_n         = arb_idx;
                ptr_n            = arb_idx;
            end else begin
                state_n = ARB_IDLE;
                grant_n = '0;
            end
        end
    end

    always_comb begin
        Haddr  = '0;
        Htrans = TR_IDLE;
        Hwrite = 1'b0;
        Hsize  = '0;
        Hburst = '0;
        if (|Hgrant) begin
            Haddr  = m_Haddr[32*int'(Hmaster) +: 32];
            Htrans = m_Htrans[2*int'(Hmaster) +: 2];
            Hwrite = m_Hwrite[Hmaster];
            Hsize  = m_Hsize[3*int'(Hmaster) +: 3];
            Hburst = m_Hburst[3*int'(Hmaster) +: 3];
        end
        Hwdata = m_Hwdata[32*int'(Hmaster_data) +: 32];
    end
endmodule

// File: tb/tb_ahb_bridge_arbiter.sv
// Directed and randomized check of ahb_bridge_arbiter against a transaction-level
// ownership model (owner, last owner, beats accepted out of burst length).
module tb_ahb_bridge_arbiter;
    localparam int N = 4;

    logic            Hclk = 1'b0;
    logic            Hresetn;
    logic [N-1:0]    req;
    logic [1:0]      htr [N];
    logic [2:0]      hbu [N];
    logic [2:0]      hsz [N];
    logic            hwr [N];
    logic [31:0]     adr [N];
    logic [31:0]     wd  [N];
    logic            rdy;

    logic [N*32-1:0] m_Haddr, m_Hwdata;
    logic [N*2-1:0]  m_Htrans;
    logic [N-1:0]    m_Hwrite;
    logic [N*3-1:0]  m_Hsize, m_Hburst;
    logic [N-1:0]    Hgrant;
    logic [1:0]      Hmaster, Hmaster_data, Htrans;
    logic            Hready, Hwrite, Hreadyin;
    logic [31:0]     Haddr, Hwdata;
    logic [2:0]      Hsize, Hburst;

    for (genvar g = 0; g < N; g++) begin : pk
        assign m_Haddr[32*g +: 32] = adr[g];
        assign m_Hwdata[32*g +: 32] = wd[g];
        assign m_Htrans[2*g +: 2]  = htr[g];
        assign m_Hsize[3*g +: 3]   = hsz[g];
        assign m_Hburst[3*g +: 3]  = hbu[g];
        assign m_Hwrite[g]         = hwr[g];
    end

    ahb_bridge_arbiter #(.NUM_MASTERS(N)) dut (
        .Hclk(Hclk), .Hresetn(Hresetn), .Hbusreq(req),
        .m_Haddr(m_Haddr), .m_Htrans(m_Htrans), .m_Hwrite(m_Hwrite),
        .m_Hsize(m_Hsize), .m_Hburst(m_Hburst), .m_Hwdata(m_Hwdata),
        .Hreadyout(rdy), .Hgrant(Hgrant), .Hmaster(Hmaster),
        .Hmaster_data(Hmaster_data), .Hready(Hready), .Haddr(Haddr),
        .Htrans(Htrans), .Hwrite(Hwrite), .Hsize(Hsize), .Hburst(Hburst),
        .Hwdata(Hwdata), .Hreadyin(Hreadyin)
    );

    always #5 Hclk = ~Hclk;

    int n_tests = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Model: owner (-1 = none), last granted, locked mode (0 none, 1 fixed, 2 incr),
    // beats accepted so far and burst length.
    int own, last, mstr, mdata, lock, done, total;

    task automatic model_reset();
        own = -1; last = 0; mstr = 0; mdata = 0; lock = 0; done = 0; total = 0;
    endtask

    task automatic model_step();
        int  ht, prev;
        bit  re;
        if (!Hresetn) begin
            model_reset();
            return;
        end
        if (!rdy) return;
        ht   = (own >= 0) ? int'(htr[own]) : 0;
        prev = mstr;
        re   = 1'b1;
        if (lock == 0) begin
            if (own >= 0 && ht == 2 && hbu[own] != 3'd0) begin
                lock  = (hbu[own] == 3'd1) ? 2 : 1;
                total = 4 << ((int'(hbu[own]) - 2) / 2);
                done  = 1;
                re    = 1'b0;
            end
        end else if (lock == 1) begin
            if (ht == 3) begin
                done++;
                re = (done == total);
            end else begin
                re = (ht != 1);
            end
        end else begin
            re = !(req[own] && (ht == 3 || ht == 1));
        end
        if (re) begin
            lock = 0;
            own  = -1;
            for (int k = 1; k <= N; k++) begin
                if (own < 0 && req[(last + k) % N]) own = (last + k) % N;
            end
            if (own >= 0) begin
                last = own;
                mstr = own;
            end
        end
        mdata = prev;
    endtask

    task automatic check_all();
        bit g;
        g = (own >= 0);
        chk("grant",        32'(Hgrant),       g ? 32'(1) << own : 32'd0);
        chk("hmaster",      32'(Hmaster),      32'(mstr));
        chk("hmaster_data", 32'(Hmaster_data), 32'(mdata));
        chk("htrans",       32'(Htrans),       g ? 32'(htr[own]) : 32'd0);
        chk("haddr",        Haddr,             g ? adr[own] : 32'd0);
        chk("hwrite",       32'(Hwrite),       g ? 32'(hwr[own]) : 32'd0);
        chk("hsize",        32'(Hsize),        g ? 32'(hsz[own]) : 32'd0);
        chk("hburst",       32'(Hburst),       g ? 32'(hbu[own]) : 32'd0);
        chk("hwdata",       Hwdata,            wd[mdata]);
        chk("hready",       32'({Hready, Hreadyin}), 32'({rdy, rdy}));
    endtask

    task automatic tick();
        @(posedge Hclk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic quiet();
        for (int i = 0; i < N; i++) begin
            htr[i] = 2'd0; hbu[i] = 3'd0; hsz[i] = 3'd2; hwr[i] = 1'b0;
            adr[i] = 32'h100 * (i + 1); wd[i] = 32'hD0D0_0000 + i;
        end
    endtask

    initial begin
        Hresetn = 1'b0; rdy = 1'b1; req = '1;
        quiet();
        model_reset();
        #3;
        chk("t1_reset_grant",  32'(Hgrant), 32'd0);
        chk("t1_reset_htrans", 32'(Htrans), 32'd0);
        chk("t1_reset_haddr",  Haddr,       32'd0);
        tick();
        Hresetn = 1'b1;
        tick();
        chk("t1_first_grant", 32'(Hgrant), 32'b0010);

        // Lone requester 2: single write, data phase follows one cycle later.
        req = 4'b0100;
        tick();
        chk("t2_grant", 32'(Hgrant), 32'b0100);
        htr[2] = 2'b10; hbu[2] = 3'b000; hwr[2] = 1'b1;
        adr[2] = 32'h0000_1000; wd[2] = 32'hCAFE_0002;
        #1;
        chk("t2_hmaster", 32'(Hmaster), 32'd2);
        chk("t2_haddr",   Haddr,        32'h0000_1000);
        tick();
        chk("t2_hmaster_data", 32'(Hmaster_data), 32'd2);
        chk("t2_hwdata",       Hwdata,            32'hCAFE_0002);

        // Round robin from reset pointer with everybody requesting singles.
        Hresetn = 1'b0; #1; Hresetn = 1'b1;
        model_reset();
        req = '1;
        for (int i = 0; i < N; i++) htr[i] = 2'b10;
        begin
            logic [3:0] seq [5];
            seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
            for (int k = 0; k < 5; k++) begin
                tick();
                chk("t3_rr_grant", 32'(Hgrant), 32'(seq[k]));
            end
        end

        // Master 1 INCR4 with a 3-cycle stall on beat 2; masters 0 and 3 waiting.
        quiet();
        req = 4'b1011;
        htr[1] = 2'b10; hbu[1] = 3'b011;
        tick();
        chk("t4_lock_b1", 32'(Hgrant), 32'b0010);
        htr[1] = 2'b11;
        rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t5_stall_grant", 32'(Hgrant), 32'b0010);
        end
        rdy = 1'b1;
        for (int b = 2; b <= 4; b++) begin
            tick();
            chk("t4_beat_grant", 32'(Hgrant), (b < 4) ? 32'b0010 : 32'b1000);
        end

        // Master 0 INCR8 cut short by IDLE after beat 2.
        quiet();
        req = 4'b0001;
        tick();
        chk("t6_grant0", 32'(Hgrant), 32'b0001);
        req = 4'b0101;
        htr[0] = 2'b10; hbu[0] = 3'b101;
        tick();
        htr[0] = 2'b11;
        tick();
        chk("t6_still_locked", 32'(Hgrant), 32'b0001);
        htr[0] = 2'b00;
        tick();
        chk("t6_early_end", 32'(Hgrant), 32'b0100);

        // Asynchronous reset mid-burst.
        htr[2] = 2'b10; hbu[2] = 3'b111;
        tick();
        htr[2] = 2'b11;
        tick();
        Hresetn = 1'b0;
        #1;
        model_reset();
        chk("t6_arst_grant",   32'(Hgrant),       32'd0);
        chk("t6_arst_htrans",  32'(Htrans),       32'd0);
        chk("t6_arst_hmaster", 32'(Hmaster),      32'd0);
        chk("t6_arst_hmdata",  32'(Hmaster_data), 32'd0);
        #1 Hresetn = 1'b1;

        // Random traffic, biased so owners tend to continue bursts.
        for (int c = 0; c < 3000; c++) begin
            rdy = ($urandom_range(0, 9) < 8);
            for (int i = 0; i < N; i++) begin
                req[i] = ($urandom_range(0, 9) < 6);
                htr[i] = 2'($urandom_range(0, 3));
                hbu[i] = 3'($urandom_range(0, 7));
                hsz[i] = 3'($urandom_range(0, 2));
                hwr[i] = 1'($urandom_range(0, 1));
                adr[i] = $urandom;
                wd[i]  = $urandom;
            end
            if (own >= 0) begin
                if ($urandom_range(0, 9) < 7) htr[own] = 2'b11;
                if ($urandom_range(0, 9) < 9) req[own] = 1'b1;
            end
            if ($urandom_range(0, 599) == 0) begin
                Hresetn = 1'b0;
                #1;
                model_reset();
                check_all();
                #1 Hresetn = 1'b1;
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
